// File: rtl/fluid_mix_seq.sv
// fluid_mix_seq -- fill / mix / flush valve sequencer for a microfluidic line.
//
// One run, started from IDLE, goes through three phases:
//   FILL   opens inlet i alone for dwell[i] cycles, channels taken in order 0..N_CH-1
//          (a channel whose dwell is 0 is skipped and takes no time)
//   MIX    keeps every valve closed for mix_cyc cycles (skipped when 0)
//   FLUSH  opens the outlet for flush_cyc cycles (skipped when 0)
// A one-cycle DONE follows, and the FSM then returns to IDLE.
// An abort during FILL, SETTLE or MIX closes the inlets, raises the sticky
// aborted flag and drains through FLUSH straight back to IDLE, without DONE.
//
// Optional feature: define FLUID_MIX_SEQ_SETTLE_EN to insert SETTLE_CYC
// all-closed cycles after every non-skipped FILL. When the macro is not
// defined, consecutive inlets switch in adjacent cycles.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a run (accepted in IDLE only)
//   abort      terminate the run and drain the line
//   dwell      fill cycles per channel, channel i at [i*CNT_W +: CNT_W]
//   mix_cyc    mix hold cycles
//   flush_cyc  outlet-open cycles
//   inlet_en   inlet valve drive, one-hot or zero
//   outlet_en  outlet valve drive
//   cur_ch     channel being filled, 0 outside FILL
//   busy       high in every state except IDLE
//   done       one-cycle pulse on normal completion
//   aborted    sticky, set by abort, cleared by the next accepted start
module fluid_mix_seq #(
    parameter int N_CH       = 3,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_CH*CNT_W-1:0]   dwell,
    input  logic [CNT_W-1:0]        mix_cyc,
    input  logic [CNT_W-1:0]        flush_cyc,
    output logic [N_CH-1:0]         inlet_en,
    output logic                    outlet_en,
    output logic [CH_W-1:0]         cur_ch,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FILL   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] MIX    = 3'd3;
    localparam logic [2:0] FLUSH  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

`ifdef FLUID_MIX_SEQ_SETTLE_EN
    localparam bit SETTLE_EN = 1'b1;
`else
    localparam bit SETTLE_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    logic [2:0]             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CH_W-1:0]        ch_q;
    logic [N_CH*CNT_W-1:0]  dwell_q;
    logic [CNT_W-1:0]       mix_q;
    logic [CNT_W-1:0]       flush_q;

    // In IDLE the run parameters come straight from the inputs so that the
    // first active state is already correct in the cycle after start.
    logic [N_CH*CNT_W-1:0]  dw_src;
    logic [CNT_W-1:0]       mix_src;
    logic [CNT_W-1:0]       flush_src;
    logic [CH_W:0]          from_ch;

    assign dw_src    = (state_q == IDLE) ? dwell     : dwell_q;
    assign mix_src   = (state_q == IDLE) ? mix_cyc   : mix_q;
    assign flush_src = (state_q == IDLE) ? flush_cyc : flush_q;
    assign from_ch   = (state_q == IDLE) ? '0 : ({1'b0, ch_q} + (CH_W+1)'(1));

    // Where the sequence goes after finishing everything before from_ch:
    // the next channel with non-zero dwell, else MIX, else FLUSH, else DONE.
    // Zero-length phases are resolved here so they consume no cycles.
    logic [2:0]        adv_state;
    logic [CH_W-1:0]   adv_ch;
    logic [CNT_W-1:0]  adv_cnt;
    logic              found;

    always_comb begin
        adv_state = DONE;
        adv_ch    = '0;
        adv_cnt   = '0;
        found     = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && ((CH_W+1)'(i) >= from_ch) &&
                (dw_src[i*CNT_W +: CNT_W] != '0)) begin
                found     = 1'b1;
                adv_state = FILL;
                adv_ch    = CH_W'(i);
                adv_cnt   = dw_src[i*CNT_W +: CNT_W] - ONE;
            end
        end
        if (!found) begin
            if (mix_src != '0) begin
                adv_state = MIX;
                adv_cnt   = mix_src - ONE;
            end else if (flush_src != '0) begin
                adv_state = FLUSH;
                adv_cnt   = flush_src - ONE;
            end
        end
    end

    logic [2:0]        nxt_state;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [CH_W-1:0]   nxt_ch;
    logic              set_ab;
    logic              clr_ab;

    // Counter holds count-1 on entry; a state is left in the cycle it reads 0.
    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q;
        nxt_ch    = ch_q;
        set_ab    = 1'b0;
        clr_ab    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_ab    = 1'b1;
                    nxt_state = adv_state;
                    nxt_ch    = adv_ch;
                    nxt_cnt   = adv_cnt;
                end
            end
            FILL, SETTLE, MIX: begin
                if (abort) begin
                    set_ab = 1'b1;
                    if (flush_q != '0) begin
                        nxt_state = FLUSH;
                        nxt_cnt   = flush_q - ONE;
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end
                end else if (cnt_q != '0) begin
                    nxt_cnt = cnt_q - ONE;
                end else if (state_q == FILL && SETTLE_EN) begin
                    nxt_state = SETTLE;
                    nxt_cnt   = SETTLE_LD;
                end else if (state_q == MIX) begin
                    nxt_state = (flush_q != '0) ? FLUSH : DONE;
                    nxt_cnt   = flush_q - ONE;
                end else begin
                    nxt_state = adv_state;
                    nxt_ch    = adv_ch;
                    nxt_cnt   = adv_cnt;
                end
            end
            FLUSH: begin
                if (cnt_q != '0) begin
                    nxt_cnt = cnt_q - ONE;
                end else begin
                    // An aborted run drains silently back to IDLE.
                    nxt_state = aborted ? IDLE : DONE;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe.
    logic [N_CH-1:0] inl_nxt;

    always_comb begin
        inl_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            inl_nxt[i] = (nxt_state == FILL) && (nxt_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            inlet_en  <= '0;
            outlet_en <= 1'b0;
            cur_ch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state_q   <= nxt_state;
            cnt_q     <= nxt_cnt;
            ch_q      <= nxt_ch;
            inlet_en  <= inl_nxt;
            outlet_en <= (nxt_state == FLUSH);
            cur_ch    <= (nxt_state == FILL) ? nxt_ch : '0;
            busy      <= (nxt_state != IDLE);
            done      <= (nxt_state == DONE);
            if (clr_ab) begin
                aborted <= 1'b0;
            end else if (set_ab) begin
                aborted <= 1'b1;
            end
        end
    end

    // Run parameters are data: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            dwell_q <= dwell;
            mix_q   <= mix_cyc;
            flush_q <= flush_cyc;
        end
    end

endmodule

// File: tb/tb_fluid_mix_seq.sv
module tb_fluid_mix_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [23:0] dwell;
    logic [7:0]  mix_cyc;
    logic [7:0]  flush_cyc;
    logic [2:0]  inlet_en;
    logic        outlet_en;
    logic [1:0]  cur_ch;
    logic        busy;
    logic        done;
    logic        aborted;

    always #5 clk = ~clk;

    fluid_mix_seq #(.N_CH(3), .CNT_W(8), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dwell(dwell), .mix_cyc(mix_cyc), .flush_cyc(flush_cyc),
        .inlet_en(inlet_en), .outlet_en(outlet_en), .cur_ch(cur_ch),
        .busy(busy), .done(done), .aborted(aborted)
    );

`ifdef FLUID_MIX_SEQ_SETTLE_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0] inl;
        logic       outl;
        logic [1:0] ch;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];

    logic [7:0] dv;
    assign dv = {inlet_en, outlet_en, cur_ch, busy, done};

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] inl, input logic outl, input logic [1:0] ch,
                        input logic dn, input int n);
        exp_t e;
        e.inl = inl; e.outl = outl; e.ch = ch; e.busy = 1'b1; e.done = dn;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Expected waveform of a whole run, one entry per cycle after start.
    task automatic build(input int d0, input int d1, input int d2, input int mx, input int fl);
        int d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        q.delete();
        for (int c = 0; c < 3; c++) begin
            if (d[c] > 0) begin
                push(3'(1 << c), 1'b0, 2'(c), 1'b0, d[c]);
                push(3'b000, 1'b0, 2'd0, 1'b0, GAP);
            end
        end
        push(3'b000, 1'b0, 2'd0, 1'b0, mx);
        push(3'b000, 1'b1, 2'd0, 1'b0, fl);
        push(3'b000, 1'b0, 2'd0, 1'b1, 1);
    endtask

    // ab_at / xs_at / rst_at: cycle at which abort / extra start / reset is applied (0 = never).
    task automatic run(input int d0, input int d1, input int d2, input int mx, input int fl,
                       input int ab_at, input int xs_at, input int rst_at,
                       input int exp_idle, input string tag);
        int k, idx, first_idle;
        logic exp_ab, ab_pend;
        exp_t e;
        build(d0, d1, d2, mx, fl);
        @(negedge clk);
        dwell = {8'(d2), 8'(d1), 8'(d0)};
        mix_cyc = 8'(mx);
        flush_cyc = 8'(fl);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // inputs are latched on start; later changes must not matter
        dwell = 24'($urandom);
        mix_cyc = 8'($urandom);
        flush_cyc = 8'($urandom);
        exp_ab = 1'b0; ab_pend = 1'b0; first_idle = -1; idx = 0; k = 1;
        while (idx < q.size()) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("%s reset outputs c%0d", tag, k), int'(dv), 0);
                chk($sformatf("%s reset aborted c%0d", tag, k), int'(aborted), 0);
                return;
            end
            e = q[idx];
            chk($sformatf("%s outputs c%0d", tag, k), int'(dv), int'(e));
            chk($sformatf("%s aborted c%0d", tag, k), int'(aborted), int'(exp_ab));
            chk($sformatf("%s invariant c%0d", tag, k),
                int'(($countones(inlet_en) <= 1) && !(outlet_en && inlet_en != 3'b000)), 1);
            if (!busy && first_idle < 0) first_idle = k;
            if (k == ab_at) begin
                abort = 1'b1;
                if (e.busy && !e.outl && !e.done) begin
                    while (q.size() > idx + 1) void'(q.pop_back());
                    push(3'b000, 1'b1, 2'd0, 1'b0, fl);
                    ab_pend = 1'b1;
                end
            end
            if (k == xs_at) start = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (ab_pend) exp_ab = 1'b1;
            idx++; k++;
        end
        if (!busy && first_idle < 0) first_idle = k;
        chk($sformatf("%s idle outputs c%0d", tag, k), int'(dv), 0);
        chk($sformatf("%s idle aborted c%0d", tag, k), int'(aborted), int'(exp_ab));
        if (exp_idle >= 0) chk($sformatf("%s first idle cycle", tag), first_idle, exp_idle);
    endtask

    typedef struct {
        int d0, d1, d2, mx, fl, ab;
        int idle_plain;   // first idle cycle, no settle gap
        int idle_settle;  // first idle cycle, 4-cycle settle gap
    } vec_t;

    initial begin
        vec_t tbl[12];
        int d0, d1, d2, mx, fl, ab, xs;

        tbl[0]  = '{2, 3, 5, 4, 3,  0,  19,  31};
        tbl[1]  = '{2, 0, 5, 4, 3,  0,  16,  24};
        tbl[2]  = '{0, 0, 0, 0, 0,  0,   2,   2};
        tbl[3]  = '{2, 3, 5, 4, 3,  4,   8,   8};
        tbl[4]  = '{0, 0, 0, 0, 2,  0,   4,   4};
        tbl[5]  = '{1, 1, 1, 0, 0,  0,   5,  17};
        tbl[6]  = '{0, 0, 0, 3, 0,  0,   5,   5};
        tbl[7]  = '{2, 3, 5, 4, 3, 12,  16,  16};
        tbl[8]  = '{1, 0, 0, 0, 0,  1,   2,   2};
        tbl[9]  = '{2, 3, 5, 4, 3, 16,  19,  20};
        tbl[10] = '{255, 0, 0, 0, 0, 0, 257, 261};
        tbl[11] = '{0, 0, 3, 0, 1,  2,   4,   4};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        dwell = '0; mix_cyc = '0; flush_cyc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", int'(dv), 0);
        chk("reset aborted", int'(aborted), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].mx, tbl[i].fl, tbl[i].ab, 0, 0,
                (GAP == 0) ? tbl[i].idle_plain : tbl[i].idle_settle,
                $sformatf("vec%0d", i));
        end

        // start during a run is ignored; reset mid-run clears everything at once
        run(2, 3, 5, 4, 3, 0, 5, 7, -1, "midreset");
        #2;
        rst_n = 1'b1;
        run(2, 3, 5, 4, 3, 0, 5, 0, (GAP == 0) ? 19 : 31, "after_reset");

        for (int r = 0; r < 25; r++) begin
            d0 = $urandom_range(0, 4);
            d1 = $urandom_range(0, 4);
            d2 = $urandom_range(0, 4);
            mx = $urandom_range(0, 4);
            fl = $urandom_range(0, 3);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
            xs = $urandom_range(1, 20);
            run(d0, d1, d2, mx, fl, ab, xs, 0, -1, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fluid_mix_seq.md
FLUID_MIX_SEQ -- requirements
Module: fluid_mix_seq

Interface
REQ-001 Parameter N_CH, default 3, number of inlet solution channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of every cycle-count field.
REQ-003 Parameter SETTLE_CYC, default 4, closed-valve gap length in cycles (1..255); used only when the settle gap is compiled in.
REQ-004 Local CH_W = max(1, clog2(N_CH)).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one fill/mix/flush run.
REQ-008 abort  in  1  terminate the run and drain the line.
REQ-009 dwell  in  N_CH*CNT_W  fill cycles per channel; channel i at bits [i*CNT_W +: CNT_W].
REQ-010 mix_cyc  in  CNT_W  diffusion-mix hold cycles.
REQ-011 flush_cyc  in  CNT_W  outlet-open cycles.
REQ-012 inlet_en  out  N_CH  inlet valve drive; one-hot or zero.
REQ-013 outlet_en  out  1  outlet valve drive.
REQ-014 cur_ch  out  CH_W  index of the channel being filled; 0 outside FILL.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 aborted  out  1  sticky flag, set by abort, cleared by the next accepted start.

Function
REQ-018 FSM states SHALL be IDLE, FILL, SETTLE, MIX, FLUSH and DONE; all outputs SHALL be registered.
REQ-019 start SHALL be accepted only in IDLE; start at edge T SHALL latch dwell, mix_cyc and flush_cyc and make the first active state visible at cycle T+1.
REQ-020 start in any non-IDLE state SHALL be ignored, with no effect on state, counters or latched values.
REQ-021 FILL for channel i SHALL hold inlet_en = (1<<i) and cur_ch = i for exactly dwell[i] cycles; channels SHALL be visited in order 0..N_CH-1.
REQ-022 A channel with dwell = 0 SHALL be skipped in zero cycles, including its gap.
REQ-023 MIX SHALL hold all valves closed for mix_cyc cycles; mix_cyc = 0 SHALL skip MIX.
REQ-024 FLUSH SHALL hold outlet_en = 1 for flush_cyc cycles; flush_cyc = 0 SHALL skip FLUSH.
REQ-025 DONE SHALL last one cycle with done = 1 and SHALL return to IDLE.
REQ-026 Invariant: inlet_en SHALL never have more than one bit set, and outlet_en SHALL never be high while any inlet_en bit is high.
REQ-027 The down-counter SHALL be CNT_W bits wide, load count-1 on state entry and leave the state when it reads 0; an all-ones count SHALL give 2^CNT_W-1 cycles with no wrap.
REQ-028 abort in FILL, SETTLE or MIX SHALL close all inlets at the next cycle, set aborted and enter FLUSH; after FLUSH the FSM SHALL return to IDLE with no done pulse.
REQ-029 abort SHALL be ignored in IDLE, FLUSH and DONE; start and abort together in IDLE SHALL accept start.
REQ-030 All-zero dwell, mix_cyc and flush_cyc SHALL go from start straight to DONE, with done at T+1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, clear counters and drive inlet_en = 0, outlet_en = 0, cur_ch = 0, busy = 0, done = 0 and aborted = 0, including mid-run.
REQ-032 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-033 With FLUID_MIX_SEQ_SETTLE_EN defined, SETTLE SHALL insert SETTLE_CYC all-closed cycles after each non-skipped FILL, before the next FILL or MIX.
REQ-034 Without FLUID_MIX_SEQ_SETTLE_EN, SETTLE SHALL not exist and inlet_en SHALL switch directly from channel i to the next non-skipped channel in adjacent cycles.

Verification
REQ-035 N_CH=3, dwell{ch0=2, ch1=3, ch2=5}, mix=4, flush=3, no macro, start@0 -> inlet 001@1-2, 010@3-5, 100@6-10; closed @11-14; outlet @15-17; done @18; busy low @19.
REQ-036 Same stimulus with FLUID_MIX_SEQ_SETTLE_EN and SETTLE_CYC=4 -> 4-cycle closed gaps after each fill; outlet @27-29; done @30.
REQ-037 Same as REQ-035 but ch1 dwell=0 -> inlet 001@1-2, 100@3-7; closed @8-11; done @15.
REQ-038 REQ-035 stimulus plus abort@4 -> inlet 0 @5; outlet @5-7; aborted=1; no done; IDLE @8; next start clears aborted.
REQ-039 Second start@5 during REQ-035 -> ignored and timing unchanged; rst_n low @7 -> all outputs 0 at once, and start after release restarts at channel 0.
